// File: rtl/uart_bus_slave_pkg.sv
// Shared definitions for the UART bus slave: register map, status bits,
// interrupt index and the line-state enum used by both serial FSMs.
package uart_bus_slave_pkg;

    localparam int unsigned IRQ_UART           = 0;
    localparam int unsigned UART_ADDRESS_WIDTH = 1;

    localparam logic [UART_ADDRESS_WIDTH-1:0] UART_REG_DATA   = 1'b0;
    localparam logic [UART_ADDRESS_WIDTH-1:0] UART_REG_STATUS = 1'b1;

    localparam int unsigned ST_TX_NOT_FULL  = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_RX_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR    = 3;
    localparam int unsigned ST_TX_IDLE      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } UartState_t;

    // Clock cycles per bit: rounded clk/baud ratio, never below 4
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned d;
        d = (clk_freq + baud / 2) / baud;
        return (d < 4) ? 4 : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO with occupancy count. A push is accepted
// when full only if a pop happens in the same cycle; a pop on empty is ignored.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_slave.sv
// Bus slave UART: DATA/STATUS registers, TX and RX FIFOs, 8N1 serialiser
// and deserialiser, and an interrupt while received data is pending.
module uart_bus_slave
    import uart_bus_slave_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 40000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] data_wr,
    input  logic [3:0]  mask,
    output logic        stall,
    output logic [31:0] data_rd,
    output logic [31:0] data_rd_2,
    output logic [5:0]  interrupt,
    output logic        txd,
    input  logic        rxd
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    // Bus decode
    logic [UART_ADDRESS_WIDTH-1:0] reg_sel;
    logic sel_data;
    logic sel_status;
    logic cpu_push;
    logic cpu_pop;
    logic status_rd;

    // FIFO interfaces
    logic [7:0] tx_head;
    logic [7:0] rx_head;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_pop, rx_push;
    logic [$clog2(FIFO_DEPTH):0] tx_count_unused;
    logic [$clog2(FIFO_DEPTH):0] rx_count_unused;

    // TX path
    UartState_t tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]    tx_idx, tx_idx_nx;
    logic [7:0]    tx_sh, tx_sh_nx;
    logic          tx_line;
    logic          txd_q;

    // RX path
    UartState_t rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_idx, rx_idx_nx;
    logic [7:0]    rx_sh, rx_sh_nx;
    logic          rx_sync1, rx_in, rx_prev;
    logic          ovr_set, ferr_set;
    logic          overrun, frame_err;

    logic unused_bits;

    assign reg_sel    = address[2 +: UART_ADDRESS_WIDTH];
    assign sel_data   = (reg_sel == UART_REG_DATA);
    assign sel_status = (reg_sel == UART_REG_STATUS);
    assign cpu_push   = write && sel_data && mask[0];
    assign cpu_pop    = read && sel_data && !rx_empty;
    assign status_rd  = read && sel_status;

    assign stall     = 1'b0;
    assign data_rd_2 = '0;
    assign txd       = txd_q;

    assign unused_bits = ^{address[31:3], address[1:0], data_wr[31:8], mask[3:1],
                           tx_count_unused, rx_count_unused};

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_push),
        .din   (data_wr[7:0]),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_sh),
        .pop   (cpu_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count_unused)
    );

    // Read mux: STATUS bits or RX head (zero when nothing is pending)
    always_comb begin
        data_rd = '0;
        if (sel_status) begin
            data_rd[ST_TX_NOT_FULL]  = !tx_full;
            data_rd[ST_RX_NOT_EMPTY] = !rx_empty;
            data_rd[ST_RX_OVERRUN]   = overrun;
            data_rd[ST_FRAME_ERR]    = frame_err;
            data_rd[ST_TX_IDLE]      = tx_empty && (tx_state == IDLE);
        end else if (!rx_empty) begin
            data_rd[7:0] = rx_head;
        end
    end

    // Interrupt vector: only the UART line is ever raised
    always_comb begin
        interrupt           = '0;
        interrupt[IRQ_UART] = !rx_empty;
    end

    // TX state register and registered line output
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            txd_q    <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_idx   <= tx_idx_nx;
            tx_sh    <= tx_sh_nx;
            txd_q    <= tx_line;
        end
    end

    // TX next state; STOP reloads straight into START so frames abut
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_idx_nx   = tx_idx;
        tx_sh_nx    = tx_sh;
        tx_pop      = 1'b0;
        tx_line     = 1'b1;
        case (tx_state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_sh_nx    = tx_head;
                    tx_cnt_nx   = '0;
                    tx_idx_nx   = '0;
                    tx_state_nx = START;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = DATA;
                end else begin
                    tx_cnt_nx = tx_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_line = tx_sh[0];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx = '0;
                    tx_sh_nx  = {1'b0, tx_sh[7:1]};
                    if (tx_idx == 3'd7) begin
                        tx_idx_nx   = '0;
                        tx_state_nx = STOP;
                    end else begin
                        tx_idx_nx = tx_idx + 1'b1;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_line = 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx = '0;
                    if (!tx_empty) begin
                        tx_pop      = 1'b1;
                        tx_sh_nx    = tx_head;
                        tx_state_nx = START;
                    end else begin
                        tx_state_nx = IDLE;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + 1'b1;
                end
            end
            default: tx_state_nx = IDLE;
        endcase
    end

    // RX synchroniser, edge history, state register and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1  <= 1'b1;
            rx_in     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_sh     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_sync1 <= rxd;
            rx_in    <= rx_sync1;
            rx_prev  <= rx_in;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_idx   <= rx_idx_nx;
            rx_sh    <= rx_sh_nx;
            if (ovr_set)        overrun <= 1'b1;
            else if (status_rd) overrun <= 1'b0;
            if (ferr_set)       frame_err <= 1'b1;
            else if (status_rd) frame_err <= 1'b0;
        end
    end

    // RX next state: mid-bit sampling referenced from the start edge
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_idx_nx   = rx_idx;
        rx_sh_nx    = rx_sh;
        rx_push     = 1'b0;
        ovr_set     = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_in) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_idx_nx   = '0;
                    rx_state_nx = rx_in ? IDLE : DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx = '0;
                    rx_sh_nx  = {rx_in, rx_sh[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_idx_nx   = '0;
                        rx_state_nx = STOP;
                    end else begin
                        rx_idx_nx = rx_idx + 1'b1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = IDLE;
                    if (rx_in) begin
                        rx_push = 1'b1;
                        ovr_set = rx_full && !cpu_pop;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + 1'b1;
                end
            end
            default: rx_state_nx = IDLE;
        endcase
    end

endmodule
